// File: rtl/fixed_point_add_sub_pipe_pkg.sv
// Shared types and constants for the fixed-point add/sub pipeline.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'd0,
    SUB     = 2'd1,
    ACC_ADD = 2'd2,
    ACC_SUB = 2'd3
  } op_e;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/fixed_point_add_sub_pipe_if.sv
// Operand/result handshake bundle for fixed_point_add_sub_pipe.
interface fixed_point_add_sub_pipe_if #(parameter int N = 32);
  import fixed_point_pkg::*;

  logic         in_valid;
  logic         in_ready;
  op_e          op;
  logic         is_signed;
  logic         saturate;
  logic         acc_clr;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         ovf;

  modport master (
    output in_valid, op, is_signed, saturate, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, c, ovf
  );

  modport slave (
    input  in_valid, op, is_signed, saturate, acc_clr, a, b, out_ready,
    output in_ready, out_valid, c, ovf
  );
endinterface

// File: rtl/fixed_point_add_sub_pipe_add.sv
// N-bit adder with carry in/out; ripple-carry structure or behavioural sum.
module Add #(
  parameter int    N     = 32,
  parameter string MODEL = "Structural",
  parameter string TOP   = "RippleCarryAdd"
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  generate
    if (MODEL == "Structural" && TOP == "RippleCarryAdd") begin : g_ripple
      logic [N:0] w_cy;
      assign w_cy[0] = ci;
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]      = a[i] ^ b[i] ^ w_cy[i];
        assign w_cy[i+1] = (a[i] & b[i]) | (w_cy[i] & (a[i] ^ b[i]));
      end
      assign co = w_cy[N];
    end else begin : g_behav
      assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    end
  endgenerate

endmodule

// File: rtl/fixed_point_add_sub_pipe.sv
// Add/sub/accumulate with overflow detect and optional saturation, computed in
// stage 1 and delayed through a globally stalled register pipeline.
module fixed_point_add_sub_pipe
  import fixed_point_pkg::*;
#(
  parameter int    N      = 32,
  parameter int    STAGES = 2,
  parameter string MODEL  = "Structural",
  parameter string TOP    = "RippleCarryAdd"
) (
  input logic                       clk,
  input logic                       rst_n,
  fixed_point_add_sub_pipe_if.slave bus
);

  localparam int DEPTH = (STAGES < STAGES_MIN) ? STAGES_MIN :
                         (STAGES > STAGES_MAX) ? STAGES_MAX : STAGES;

  logic         w_adv, w_accept, w_sub, w_acc_op, w_co, w_ovf;
  logic [N-1:0] w_x, w_xi, w_s, w_sat, w_res;
  logic [N-1:0] r_acc;

  logic [DEPTH:1]        r_vld_pipe;
  logic [DEPTH:1]        r_ovf;
  logic [DEPTH:1][N-1:0] r_c;

  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;
  assign w_accept     = bus.in_valid && w_adv;

  assign w_sub    = (bus.op == SUB) || (bus.op == ACC_SUB);
  assign w_acc_op = (bus.op == ACC_ADD) || (bus.op == ACC_SUB);
  assign w_x      = w_acc_op ? (bus.acc_clr ? '0 : r_acc) : bus.b;
  // Subtraction is a + ~X + 1, so the inverted operand is the effective one.
  assign w_xi     = w_x ^ {N{w_sub}};

  Add #(.N(N), .MODEL(MODEL), .TOP(TOP)) u_add (
    .a  (bus.a),
    .b  (w_xi),
    .ci (w_sub),
    .s  (w_s),
    .co (w_co)
  );

  always_comb begin
    w_ovf = 1'b0;
    w_sat = '0;
    if (bus.is_signed) begin
      w_ovf = (bus.a[N-1] == w_xi[N-1]) && (w_s[N-1] != bus.a[N-1]);
      w_sat = bus.a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      // carry set on add = overflow; carry clear on sub = borrow
      w_ovf = w_co ^ w_sub;
      w_sat = w_sub ? '0 : '1;
    end
  end

  assign w_res = (bus.saturate && w_ovf) ? w_sat : w_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_acc_op)         r_acc <= w_res;
      else if (bus.acc_clr) r_acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_ovf      <= '0;
      r_c        <= '0;
    end else if (w_adv) begin
      r_vld_pipe[1] <= w_accept;
      r_ovf[1]      <= w_accept && w_ovf;
      r_c[1]        <= w_res;
      for (int i = 2; i <= DEPTH; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_ovf[i]      <= r_ovf[i-1];
        r_c[i]        <= r_c[i-1];
      end
    end
  end

  assign bus.out_valid = r_vld_pipe[DEPTH];
  assign bus.ovf       = r_ovf[DEPTH];
  assign bus.c         = r_c[DEPTH];

endmodule

// File: tb/tb_fixed_point_add_sub_pipe.sv
// Four DUTs (STAGES=1..4, N=8) share stimulus; each has its own scoreboard
// fed by an arithmetic reference model. Directed checks target STAGES=2.
module tb_fixed_point_add_sub_pipe;
  import fixed_point_pkg::*;

  localparam int N  = 8;
  localparam int NI = 4;
  localparam int MAIN = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         s_in_valid, s_sgn, s_sat, s_clr;
  op_e          s_op;
  logic [N-1:0] s_a, s_b;
  logic [NI-1:0] ordy;

  logic [NI-1:0]        w_ir, w_ov, w_ovf;
  logic [NI-1:0][N-1:0] w_c;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fixed_point_add_sub_pipe_if #(.N(N)) bus ();
    assign bus.in_valid  = s_in_valid;
    assign bus.op        = s_op;
    assign bus.is_signed = s_sgn;
    assign bus.saturate  = s_sat;
    assign bus.acc_clr   = s_clr;
    assign bus.a         = s_a;
    assign bus.b         = s_b;
    assign bus.out_ready = ordy[g];
    assign w_ir[g]  = bus.in_ready;
    assign w_ov[g]  = bus.out_valid;
    assign w_ovf[g] = bus.ovf;
    assign w_c[g]   = bus.c;

    fixed_point_add_sub_pipe #(
      .N(N), .STAGES(g + 1),
      .MODEL(g == 3 ? "Behavioral" : "Structural"), .TOP("RippleCarryAdd")
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference: true integer result, range-checked and clamped.
  function automatic logic [8:0] ref_op(input op_e op, input bit sgn, input bit sat,
                                        input logic [7:0] a, input logic [7:0] x);
    int ra, rx, r, lo, hi;
    bit ov;
    if (sgn) begin
      ra = int'($signed(a)); rx = int'($signed(x)); lo = -128; hi = 127;
    end else begin
      ra = int'(a); rx = int'(x); lo = 0; hi = 255;
    end
    r  = (op == SUB || op == ACC_SUB) ? ra - rx : ra + rx;
    ov = (r < lo) || (r > hi);
    if (sat && ov) r = (r > hi) ? hi : lo;
    return {ov, r[7:0]};
  endfunction

  typedef struct { logic [7:0] c; logic ovf; int cyc; int st; } exp_t;
  exp_t         q[NI][$];
  logic [7:0]   m_acc[NI];
  int           stalls[NI];
  int           n_out[NI];
  int           cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] x;
    logic [8:0] r;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        q[i].delete();
        m_acc[i]  = '0;
        stalls[i] = 0;
      end else begin
        if (w_ov[i] && ordy[i]) begin
          n_out[i]++;
          if (q[i].size() == 0) begin
            chk($sformatf("spurious_s%0d", i + 1), 1, 0);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("c_s%0d", i + 1), w_c[i], e.c);
            chk($sformatf("ovf_s%0d", i + 1), w_ovf[i], e.ovf);
            chk($sformatf("lat_s%0d", i + 1), cyc, e.cyc + i + 1 + stalls[i] - e.st);
          end
        end
        if (s_in_valid && w_ir[i]) begin
          x = (s_op == ACC_ADD || s_op == ACC_SUB) ? (s_clr ? 8'd0 : m_acc[i]) : s_b;
          r = ref_op(s_op, s_sgn, s_sat, s_a, x);
          if (s_op == ACC_ADD || s_op == ACC_SUB) m_acc[i] = r[7:0];
          else if (s_clr)                         m_acc[i] = '0;
          e.c = r[7:0]; e.ovf = r[8]; e.cyc = cyc; e.st = stalls[i];
          q[i].push_back(e);
        end
        if (w_ov[i] && !ordy[i]) stalls[i]++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input op_e op, input bit sgn, input bit sat, input bit clr,
                      input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    s_op = op; s_sgn = sgn; s_sat = sat; s_clr = clr; s_a = a; s_b = b;
    s_in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (w_ir[MAIN]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic run_one(input op_e op, input bit sgn, input bit sat, input bit clr,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ec, input bit eo, input string tag);
    ordy = '1;
    send(op, sgn, sat, clr, a, b);
    @(negedge clk);
    chk({tag, "_early"}, w_ov[MAIN], 0);
    @(negedge clk);
    chk({tag, "_vld"}, w_ov[MAIN], 1);
    chk({tag, "_c"}, w_c[MAIN], ec);
    chk({tag, "_ovf"}, w_ovf[MAIN], eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; ordy = '1;
    s_in_valid = 0; s_op = ADD; s_sgn = 0; s_sat = 0; s_clr = 0; s_a = 0; s_b = 0;
    for (int i = 0; i < NI; i++) begin m_acc[i] = 0; stalls[i] = 0; n_out[i] = 0; end
    #3;
    chk("rst_vld", w_ov[MAIN], 0);
    chk("rst_c", w_c[MAIN], 0);
    chk("rst_ovf", w_ovf[MAIN], 0);
    chk("rst_rdy", w_ir[MAIN], 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_post_rst", w_ir[MAIN], 1);
    @(posedge clk); #1;

    run_one(ADD, 0, 1, 0, 8'd200, 8'd100, 8'd255, 1, "uadd_sat");
    run_one(ADD, 0, 0, 0, 8'd200, 8'd100, 8'd44,  1, "uadd_wrap");
    run_one(SUB, 1, 1, 0, 8'h80, 8'h01, 8'h80, 1, "ssub_sat");
    run_one(SUB, 1, 0, 0, 8'h80, 8'h01, 8'h7F, 1, "ssub_wrap");
    run_one(ADD, 1, 1, 0, 8'h7F, 8'h01, 8'h7F, 1, "sadd_sat");
    run_one(SUB, 0, 1, 0, 8'd5, 8'd9, 8'd0, 1, "usub_sat");

    run_one(ACC_ADD, 0, 0, 1, 8'd10, 8'd0, 8'd10, 0, "acc10");
    run_one(ACC_ADD, 0, 0, 0, 8'd20, 8'd0, 8'd30, 0, "acc30");
    run_one(ACC_ADD, 0, 0, 0, 8'd30, 8'd0, 8'd60, 0, "acc60");
    run_one(ACC_ADD, 0, 0, 1, 8'd5,  8'd0, 8'd5,  0, "acc_clr5");
    run_one(ACC_SUB, 0, 0, 0, 8'd12, 8'd0, 8'd7,  0, "accsub");
    run_one(ACC_ADD, 0, 1, 1, 8'd250, 8'd0, 8'd250, 0, "acc250");
    run_one(ACC_ADD, 0, 1, 0, 8'd10,  8'd0, 8'd255, 1, "acc_sat");

    // Backpressure on the STAGES=2 instance
    ordy = '1; ordy[MAIN] = 1'b0;
    base = n_out[MAIN];
    send(ADD, 0, 0, 0, 8'd1, 8'd1);
    send(ADD, 0, 0, 0, 8'd2, 8'd2);
    s_op = ADD; s_a = 8'd3; s_b = 8'd3; s_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rdy", w_ir[MAIN], 0);
      chk("bp_hold", w_ov[MAIN], 1);
    end
    @(posedge clk); #1;
    ordy[MAIN] = 1'b1;
    send(ADD, 0, 0, 0, 8'd3, 8'd3);
    send(ADD, 0, 0, 0, 8'd4, 8'd4);
    repeat (6) @(posedge clk); #1;
    chk("bp_count", n_out[MAIN] - base, 4);

    // Reset with acc=60 and two results in flight
    run_one(ACC_ADD, 0, 0, 1, 8'd10, 8'd0, 8'd10, 0, "r_acc10");
    run_one(ACC_ADD, 0, 0, 0, 8'd20, 8'd0, 8'd30, 0, "r_acc30");
    run_one(ACC_ADD, 0, 0, 0, 8'd30, 8'd0, 8'd60, 0, "r_acc60");
    send(ADD, 0, 0, 0, 8'd7, 8'd8);
    send(ADD, 0, 0, 0, 8'd9, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", w_ov[MAIN], 0);
    chk("mid_rst_c", w_c[MAIN], 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk($sformatf("stale_s%0d", i + 1), w_ov[i], 0);
    end
    @(posedge clk); #1;
    run_one(ACC_ADD, 0, 0, 0, 8'd1, 8'd0, 8'd1, 0, "post_rst_acc");

    // Random traffic with random backpressure, all depths
    for (int k = 0; k < 800; k++) begin
      s_in_valid = ($urandom_range(0, 3) != 0);
      s_op  = op_e'($urandom_range(0, 3));
      s_sgn = $urandom_range(0, 1);
      s_sat = $urandom_range(0, 1);
      s_clr = ($urandom_range(0, 7) == 0);
      s_a   = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
      s_b   = ($urandom_range(0, 5) == 0) ? 8'h7F : 8'($urandom);
      for (int i = 0; i < NI; i++) ordy[i] = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0; ordy = '1;
    repeat (10) @(posedge clk); #1;
    for (int i = 0; i < NI; i++) chk($sformatf("drain_s%0d", i + 1), q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_point_add_sub_pipe.md
FIXED_POINT_ADD_SUB_PIPE -- requirements
Module: fixed_point_add_sub_pipe

Interface
REQ-001 Parameter N, default 32: operand and result width in bits, N >= 2.
REQ-002 Parameter STAGES, default 2: pipeline depth in registers, range 1..4.
REQ-003 Parameter MODEL, default "Structural": modeling technique, passed to the adder sub-module.
REQ-004 Parameter TOP, default "RippleCarryAdd": adder architecture, passed to the adder sub-module.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  the operand set is valid.
REQ-008 in_ready  output  1  the block accepts the operand set this cycle.
REQ-009 op  input  2  operation: ADD=0, SUB=1, ACC_ADD=2, ACC_SUB=3.
REQ-010 is_signed  input  1  1 selects two's-complement interpretation; 0 selects unsigned.
REQ-011 saturate  input  1  1 clamps on overflow; 0 wraps.
REQ-012 acc_clr  input  1  clears the accumulator; sampled on acceptance only.
REQ-013 a, b  input  N each  operands; b is ignored for ACC_* ops.
REQ-014 out_valid  output  1  the result is valid.
REQ-015 out_ready  input  1  the downstream accepts the result.
REQ-016 c  output  N  result.
REQ-017 ovf  output  1  overflow/underflow occurred, whether or not the result saturated.

Function
REQ-018 Acceptance SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-019 Pipeline advance SHALL be global: adv = !out_valid || out_ready; in_ready = adv.
REQ-020 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when there is no backpressure, with a throughput of 1 per cycle.
REQ-021 When adv=0, all stage registers SHALL hold; no result is dropped or duplicated; results leave in acceptance order.
REQ-022 All arithmetic and saturation SHALL complete in stage 1; stages 2..STAGES only delay data, valid, and ovf.
REQ-023 Operand X = b for ADD/SUB; X = accumulator (acc) for ACC_*, with X = 0 if acc_clr is set in the same acceptance.
  - For ADD/ACC_ADD, the sum is computed as a + X with carry-in 0.
  - For SUB/ACC_SUB, the sum is computed as a + ~X with carry-in 1.
  - The computation is N+1 bits wide, with carry out co.
  - For ACC_SUB the result is a - acc.
REQ-024 Unsigned overflow SHALL be: add and co=1 gives overflow; sub and co=0 gives underflow.
REQ-025 Signed overflow SHALL be flagged when a and the effective second operand have the same sign and the result sign differs.
REQ-026 Saturation, when saturate=1 and overflow occurs:
  - unsigned overflow SHALL give all ones; unsigned underflow SHALL give 0;
  - signed overflow with a positive sign of a SHALL give 2^(N-1)-1; with a negative sign SHALL give -2^(N-1).
REQ-027 When saturate=0, the result SHALL be the low N bits of the sum.
REQ-028 acc SHALL update to the final (saturated or wrapped) result on each accepted ACC_* op.
REQ-029 acc_clr accepted with ADD/SUB SHALL set acc=0.
REQ-030 acc_clr accepted with ACC_* SHALL make acc equal to that op's result computed with X=0.
REQ-031 acc SHALL NOT change on cycles without acceptance.

Reset
REQ-032 While rst_n=0, the following SHALL be forced asynchronously: out_valid=0, c=0, ovf=0, acc=0, and all stage valid bits 0.
REQ-033 in_ready SHALL be 1 while rst_n=0 and in the first cycle after release.
REQ-034 Reset mid-operation SHALL discard all in-flight results; no partial result appears after release.

Structure
REQ-035 Package fixed_point_pkg SHALL hold the op_e enum (ADD, SUB, ACC_ADD, ACC_SUB) and the STAGES bounds constants.
REQ-036 The N+1-bit sum SHALL be produced by one instance of the team's existing Add sub-module, passing MODEL and TOP, ci = subtract.
REQ-037 Saturation, acc, and pipeline registers SHALL be local to this module.

Verification (N=8, STAGES=2 unless stated)
REQ-038 Unsigned ADD 200+100 with saturate=1 -> c=255, ovf=1; with saturate=0 -> c=44, ovf=1; output 2 cycles after acceptance.
REQ-039 Signed SUB 0x80-0x01 with saturate=1 -> c=0x80, ovf=1; with saturate=0 -> c=0x7F, ovf=1. Signed ADD 0x7F+0x01 with saturate=1 -> c=0x7F, ovf=1.
REQ-040 Backpressure: send 4 back-to-back results with out_ready=0 for 3 cycles -> in_ready=0 while stalled, all 4 results delivered in order, none lost or duplicated.
REQ-041 Accumulate:
  - ACC_ADD a=10 with acc_clr=1, then a=20, then a=30 -> c=10, 30, 60;
  - then ACC_ADD a=5 with acc_clr=1 -> c=5;
  - unsigned ACC_ADD 250 then 10 with saturate=1 -> 255, ovf=1.
REQ-042 Reset: assert rst_n=0 with 2 results in flight and acc=60 -> out_valid=0 immediately; after release, no stale output appears and the next ACC_ADD 1 gives c=1.
REQ-043 Sweep STAGES=1..4 with random ops against a reference model -> bit-exact c and ovf, latency equal to STAGES.
